// File: rtl/ni.sv
// GPU <-> NoC router network interface with independent TX/RX flit queues.
// Rewrites the 6-bit flit header between GPU IDs and router routing headers.

module ni_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    // A pop frees the slot being overwritten, so full+pop may still push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end
endmodule

module ni #(
    parameter int GPU_ID     = 0,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] gpu_data_in,
    input  logic              gpu_valid_in,
    output logic              gpu_ready_out,
    output logic [DATA_W-1:0] gpu_data_out,
    output logic              gpu_valid_out,
    input  logic              gpu_ready_in,
    output logic [DATA_W-1:0] router_data_out,
    output logic              router_valid_out,
    input  logic              router_ready_in,
    input  logic [DATA_W-1:0] router_data_in,
    input  logic              router_valid_in
);
    localparam logic [5:0] GID6   = 6'(GPU_ID);
    localparam logic [5:0] MY_HDR = GID6 << 1;

    logic [5:0]        tx_id;
    logic [5:0]        tx_hdr;
    logic [DATA_W-1:0] tx_wdata;
    logic              tx_full, tx_empty;
    logic              tx_push, tx_pop;

    logic [DATA_W-1:0] rx_wdata;
    logic              rx_full, rx_empty;
    logic              rx_match, rx_pop;

    assign tx_id    = gpu_data_in[DATA_W-1 -: 6];
    assign tx_hdr   = tx_id << 1;
    assign tx_wdata = {tx_hdr, gpu_data_in[DATA_W-7:0]};

    assign gpu_ready_out    = !tx_full;
    assign tx_push          = gpu_valid_in && !tx_full;
    assign router_valid_out = !tx_empty;
    assign tx_pop           = router_valid_out && router_ready_in;

    ni_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (tx_wdata),
        .rdata_o (router_data_out),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // RX has no backpressure; the FIFO drops a match that finds it full.
    assign rx_match = router_valid_in
                   && (router_data_in[DATA_W-1 -: 6] == MY_HDR);
    assign rx_wdata = {GID6, router_data_in[DATA_W-7:0]};

    assign gpu_valid_out = !rx_empty;
    assign rx_pop        = gpu_valid_out && gpu_ready_in;

    ni_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (rx_match),
        .pop_i   (rx_pop),
        .wdata_i (rx_wdata),
        .rdata_o (gpu_data_out),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    logic unused_rx_full;
    assign unused_rx_full = rx_full;
endmodule

// File: tb/tb_ni.sv
// Scoreboard bench for ni: GPU_ID=3, 16-bit flits, depth-4 queues.

module tb_ni;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int GID   = 3;
    localparam logic [5:0] MY = 6'd6;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] gpu_data_in;
    logic          gpu_valid_in;
    logic          gpu_ready_out;
    logic [DW-1:0] gpu_data_out;
    logic          gpu_valid_out;
    logic          gpu_ready_in;
    logic [DW-1:0] router_data_out;
    logic          router_valid_out;
    logic          router_ready_in;
    logic [DW-1:0] router_data_in;
    logic          router_valid_in;

    ni #(.GPU_ID(GID), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .gpu_data_in      (gpu_data_in),
        .gpu_valid_in     (gpu_valid_in),
        .gpu_ready_out    (gpu_ready_out),
        .gpu_data_out     (gpu_data_out),
        .gpu_valid_out    (gpu_valid_out),
        .gpu_ready_in     (gpu_ready_in),
        .router_data_out  (router_data_out),
        .router_valid_out (router_valid_out),
        .router_ready_in  (router_ready_in),
        .router_data_in   (router_data_in),
        .router_valid_in  (router_valid_in)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    int m_tx = 0;
    int m_rx = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] tx_exp(input logic [DW-1:0] d);
        int id;
        id = int'(d[DW-1 -: 6]);
        return {6'((id * 2) % 64), d[DW-7:0]};
    endfunction

    function automatic logic [DW-1:0] rx_exp(input logic [DW-1:0] d);
        return {6'(GID), d[DW-7:0]};
    endfunction

    // One clock: check at negedge, update model, return 1 after posedge.
    task automatic cyc();
        logic [DW-1:0] e;
        bit tpop;
        bit rpop;
        @(negedge clk);
        chk("tx_valid", 32'(router_valid_out), 32'(m_tx > 0));
        chk("rx_valid", 32'(gpu_valid_out), 32'(m_rx > 0));
        if (router_valid_out && router_ready_in) begin
            chk("tx_q_has_exp", 32'(txq.size() > 0), 32'd1);
            if (txq.size() > 0) begin
                e = txq.pop_front();
                chk("tx_data", 32'(router_data_out), 32'(e));
            end
        end
        if (gpu_valid_out && gpu_ready_in) begin
            chk("rx_q_has_exp", 32'(rxq.size() > 0), 32'd1);
            if (rxq.size() > 0) begin
                e = rxq.pop_front();
                chk("rx_data", 32'(gpu_data_out), 32'(e));
            end
        end
        tpop = (m_tx > 0) && router_ready_in;
        if (gpu_valid_in) begin
            chk("gpu_ready", 32'(gpu_ready_out), 32'(m_tx < DEPTH));
            if (m_tx < DEPTH) begin
                txq.push_back(tx_exp(gpu_data_in));
                m_tx++;
            end
        end
        if (tpop) m_tx--;
        rpop = (m_rx > 0) && gpu_ready_in;
        if (router_valid_in && router_data_in[DW-1 -: 6] == MY
            && (m_rx < DEPTH || rpop)) begin
            rxq.push_back(rx_exp(router_data_in));
            m_rx++;
        end
        if (rpop) m_rx--;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        gpu_data_in     = '0;
        gpu_valid_in    = 1'b0;
        gpu_ready_in    = 1'b0;
        router_ready_in = 1'b0;
        router_data_in  = '0;
        router_valid_in = 1'b0;
        #12;
        chk("rst_tx_valid", 32'(router_valid_out), 32'd0);
        chk("rst_rx_valid", 32'(gpu_valid_out), 32'd0);
        chk("rst_tx_data", 32'(router_data_out), 32'd0);
        chk("rst_rx_data", 32'(gpu_data_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(gpu_ready_out), 32'd1);

        // TX header rewrite
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        gpu_valid_in    = 1'b1;
        gpu_data_in     = 16'h16AA;
        cyc();
        chk("t1_v", 32'(router_valid_out), 32'd1);
        chk("t1_a", 32'(router_data_out), 32'h2AAA);
        gpu_data_in = 16'h1FBB;
        cyc();
        chk("t1_b", 32'(router_data_out), 32'h3BBB);
        gpu_data_in = 16'h08CC;
        cyc();
        chk("t1_c", 32'(router_data_out), 32'h10CC);
        gpu_valid_in = 1'b0;
        repeat (2) cyc();

        // RX match and rewrite, back to back
        router_valid_in = 1'b1;
        router_data_in  = 16'h1A11;
        cyc();
        chk("t2_a", 32'(gpu_data_out), 32'h0E11);
        router_data_in = 16'h1A22;
        cyc();
        chk("t2_b", 32'(gpu_data_out), 32'h0E22);
        router_data_in = 16'h1A33;
        cyc();
        chk("t2_c", 32'(gpu_data_out), 32'h0E33);
        router_valid_in = 1'b0;
        repeat (2) cyc();

        // RX non-matching flit dropped
        router_valid_in = 1'b1;
        router_data_in  = 16'h2AAA;
        cyc();
        router_valid_in = 1'b0;
        chk("t3_drop", 32'(gpu_valid_out), 32'd0);
        cyc();

        // TX backpressure
        router_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gpu_valid_in = 1'b1;
            gpu_data_in  = {6'(i + 1), 10'(16'h100 + i)};
            cyc();
        end
        gpu_valid_in = 1'b0;
        chk("t4_full", 32'(gpu_ready_out), 32'd0);
        chk("t4_qd", 32'(txq.size()), 32'd4);
        router_ready_in = 1'b1;
        repeat (6) cyc();
        chk("t4_ready", 32'(gpu_ready_out), 32'd1);
        chk("t4_drain", 32'(txq.size()), 32'd0);

        // RX full: drop without pop, keep with pop
        gpu_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            router_valid_in = 1'b1;
            router_data_in  = {MY, 10'(i * 37 + 5)};
            cyc();
        end
        router_valid_in = 1'b0;
        chk("t5_qd", 32'(rxq.size()), 32'd4);
        gpu_ready_in = 1'b1;
        repeat (6) cyc();
        chk("t5_drain", 32'(rxq.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            gpu_ready_in    = (i == 4);
            router_valid_in = 1'b1;
            router_data_in  = {MY, 10'(i * 91 + 3)};
            cyc();
        end
        router_valid_in = 1'b0;
        chk("t5_qd2", 32'(rxq.size()), 32'd4);
        repeat (6) cyc();
        chk("t5_drain2", 32'(rxq.size()), 32'd0);

        // Mixed traffic on both paths
        for (int i = 0; i < 60; i++) begin
            gpu_valid_in    = 1'($urandom_range(0, 1));
            gpu_data_in     = 16'($urandom);
            router_ready_in = 1'($urandom_range(0, 1));
            gpu_ready_in    = 1'($urandom_range(0, 1));
            router_valid_in = 1'($urandom_range(0, 1));
            router_data_in  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) router_data_in[15:10] = MY;
            cyc();
        end
        gpu_valid_in    = 1'b0;
        router_valid_in = 1'b0;
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        repeat (6) cyc();
        chk("mix_tx_drain", 32'(txq.size()), 32'd0);
        chk("mix_rx_drain", 32'(rxq.size()), 32'd0);

        // Reset with both queues occupied
        router_ready_in = 1'b0;
        gpu_ready_in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gpu_valid_in    = 1'b1;
            gpu_data_in     = 16'h0400 + 16'(i);
            router_valid_in = 1'b1;
            router_data_in  = {MY, 10'(16'h50 + i)};
            cyc();
        end
        gpu_valid_in    = 1'b0;
        router_valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_tx_valid", 32'(router_valid_out), 32'd0);
        chk("t6_rx_valid", 32'(gpu_valid_out), 32'd0);
        chk("t6_tx_data", 32'(router_data_out), 32'd0);
        txq.delete();
        rxq.delete();
        m_tx = 0;
        m_rx = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        repeat (5) cyc();
        chk("t6_ready", 32'(gpu_ready_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
